// File: rtl/instruction_fetcher.sv
// Dual-issue fetch: one 8-byte-aligned read per cycle, doubleword split into program-ordered slots A/B.
// Latency: slots register 2 edges after their address is presented; a redirect costs one bubble packet.
// Backpressure: stall freezes all state and re-presents the in-flight address. Optional STATIC_BTFN_EN adds BTFN prediction.
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] fetchedInstruction,
    input  logic        stall,
    input  logic [31:0] branchTarget,
    input  logic        branchTaken,
    output logic [31:0] instructionAddress,
    output logic [31:0] instructionA,
    output logic [31:0] instructionB,
    output logic        instructionA_valid,
    output logic        instructionB_valid,
    output logic [31:0] addressA,
    output logic [31:0] addressB,
    output logic        predTakenA,
    output logic        predTakenB
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_vld_q, req_vld_d;
    logic [31:0] instr_a_q, instr_a_d, instr_b_q, instr_b_d;
    logic [31:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic        a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [31:0] slot_a, slot_b;
    logic        slot_b_vld;

`ifdef STATIC_BTFN_EN
    logic pred_a_q, pred_a_d, pred_b_q, pred_b_d;

    function automatic logic pred_hit(input logic [31:0] w);
        return ((w[6:0] == 7'b1100011) && w[31]) || (w[6:0] == 7'b1101111);
    endfunction

    function automatic logic [31:0] pred_tgt(input logic [31:0] w, input logic [31:0] pc);
        logic [31:0] imm;
        if (w[6:0] == 7'b1101111) imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        else                      imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        return (pc + imm) & ~32'h3;
    endfunction
`endif

    // While stalled the in-flight request is re-read so its data is still there on release.
    assign instructionAddress = (stall ? req_pc_q : pc_q) & ~32'h7;

    always_comb begin
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        req_vld_d = req_vld_q;
        instr_a_d = instr_a_q;
        instr_b_d = instr_b_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        a_vld_d   = a_vld_q;
        b_vld_d   = b_vld_q;
`ifdef STATIC_BTFN_EN
        pred_a_d  = pred_a_q;
        pred_b_d  = pred_b_q;
`endif
        slot_a     = req_pc_q[2] ? fetchedInstruction[63:32] : fetchedInstruction[31:0];
        slot_b     = req_pc_q[2] ? 32'h0 : fetchedInstruction[63:32];
        slot_b_vld = req_vld_q & ~req_pc_q[2];

        if (branchTaken) begin
            pc_d      = branchTarget & ~32'h3;
            req_vld_d = 1'b0;
            a_vld_d   = 1'b0;
            b_vld_d   = 1'b0;
`ifdef STATIC_BTFN_EN
            pred_a_d  = 1'b0;
            pred_b_d  = 1'b0;
`endif
        end else if (!stall) begin
            req_pc_d  = pc_q;
            req_vld_d = 1'b1;
            pc_d      = (pc_q & ~32'h7) + 32'd8;
            instr_a_d = slot_a;
            instr_b_d = slot_b;
            addr_a_d  = req_pc_q;
            addr_b_d  = req_pc_q + 32'd4;
            a_vld_d   = req_vld_q;
            b_vld_d   = slot_b_vld;
`ifdef STATIC_BTFN_EN
            pred_a_d  = 1'b0;
            pred_b_d  = 1'b0;
            // Only the oldest predicted-taken slot steers fetch; younger slot is dropped.
            if (req_vld_q && pred_hit(slot_a)) begin
                pred_a_d  = 1'b1;
                b_vld_d   = 1'b0;
                pc_d      = pred_tgt(slot_a, req_pc_q);
                req_vld_d = 1'b0;
            end else if (slot_b_vld && pred_hit(slot_b)) begin
                pred_b_d  = 1'b1;
                pc_d      = pred_tgt(slot_b, req_pc_q + 32'd4);
                req_vld_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= 32'h0;
            req_vld_q <= 1'b0;
            instr_a_q <= 32'h0;
            instr_b_q <= 32'h0;
            addr_a_q  <= 32'h0;
            addr_b_q  <= 32'h0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
`ifdef STATIC_BTFN_EN
            pred_a_q  <= 1'b0;
            pred_b_q  <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            req_vld_q <= req_vld_d;
            instr_a_q <= instr_a_d;
            instr_b_q <= instr_b_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            a_vld_q   <= a_vld_d;
            b_vld_q   <= b_vld_d;
`ifdef STATIC_BTFN_EN
            pred_a_q  <= pred_a_d;
            pred_b_q  <= pred_b_d;
`endif
        end
    end

    assign instructionA       = instr_a_q;
    assign instructionB       = instr_b_q;
    assign addressA           = addr_a_q;
    assign addressB           = addr_b_q;
    assign instructionA_valid = a_vld_q;
    assign instructionB_valid = b_vld_q;
`ifdef STATIC_BTFN_EN
    assign predTakenA = pred_a_q;
    assign predTakenB = pred_b_q;
`else
    assign predTakenA = 1'b0;
    assign predTakenB = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: synchronous memory model, stream-level reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_instruction_fetcher;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic [63:0] fetchedInstruction = 64'h0;
    logic [31:0] instructionAddress, instructionA, instructionB, addressA, addressB;
    logic        instructionA_valid, instructionB_valid, predTakenA, predTakenB;

    logic [31:0] words [0:511];
    int n_vec = 0;
    int n_err = 0;

    instruction_fetcher dut (
        .clk(clk), .reset(reset), .fetchedInstruction(fetchedInstruction), .stall(stall),
        .branchTarget(branchTarget), .branchTaken(branchTaken),
        .instructionAddress(instructionAddress), .instructionA(instructionA), .instructionB(instructionB),
        .instructionA_valid(instructionA_valid), .instructionB_valid(instructionB_valid),
        .addressA(addressA), .addressB(addressB), .predTakenA(predTakenA), .predTakenB(predTakenB)
    );

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < 512; k++)
            words[k] = (k < 16) ? 32'h1111_1111 * k : ((32'(k) << 12) | 32'h13);
        words[13] = 32'hFE00_00E3;
    end

    // Synchronous 64-bit memory, one cycle read latency.
    always @(posedge clk)
        fetchedInstruction <= {words[{instructionAddress[10:3], 1'b1}], words[{instructionAddress[10:3], 1'b0}]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: next fetch address, one in-flight request, expected slot contents.
    logic [31:0] m_next = 32'h0, m_inf = 32'h0;
    logic        m_inf_vld = 1'b0;
    logic        e_av = 1'b0, e_bv = 1'b0, e_bchk = 1'b0, e_pa = 1'b0, e_pb = 1'b0;
    logic [31:0] e_a = 32'h0, e_b = 32'h0, e_aa = 32'h0, e_ab = 32'h0;

`ifdef STATIC_BTFN_EN
    function automatic logic m_taken(input logic [31:0] w);
        return ((w[6:0] == 7'h63) && w[31]) || (w[6:0] == 7'h6F);
    endfunction
    function automatic logic [31:0] m_target(input logic [31:0] w, input logic [31:0] pc);
        int off;
        if (w[6:0] == 7'h6F) off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        else                 off = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        return (pc + 32'(off)) & ~32'h3;
    endfunction
`endif

    task automatic model_step();
        if (!reset) begin
            m_next = 32'h0; m_inf = 32'h0; m_inf_vld = 1'b0;
            e_av = 1'b0; e_bv = 1'b0; e_pa = 1'b0; e_pb = 1'b0; e_bchk = 1'b0;
            e_a = 32'h0; e_b = 32'h0; e_aa = 32'h0; e_ab = 32'h0;
        end else if (branchTaken) begin
            m_next = branchTarget & ~32'h3;
            m_inf_vld = 1'b0;
            e_av = 1'b0; e_bv = 1'b0; e_pa = 1'b0; e_pb = 1'b0;
        end else if (!stall) begin
            e_av = m_inf_vld;
            e_aa = m_inf;
            e_ab = m_inf + 32'd4;
            e_a  = words[m_inf[10:2]];
            e_bchk = 1'b1;
            if (m_inf[2]) begin
                e_bv = 1'b0; e_b = 32'h0;
            end else begin
                e_bv = m_inf_vld; e_b = words[{m_inf[10:3], 1'b1}];
            end
            e_pa = 1'b0; e_pb = 1'b0;
            m_inf = m_next;
            m_inf_vld = 1'b1;
            m_next = (m_next & ~32'h7) + 32'd8;
`ifdef STATIC_BTFN_EN
            if (e_av && m_taken(e_a)) begin
                e_pa = 1'b1; e_bv = 1'b0; e_bchk = 1'b0;
                m_next = m_target(e_a, e_aa); m_inf_vld = 1'b0;
            end else if (e_bv && m_taken(e_b)) begin
                e_pb = 1'b1;
                m_next = m_target(e_b, e_ab); m_inf_vld = 1'b0;
            end
`endif
        end
    endtask

    always @(posedge clk or negedge reset) model_step();

    always @(negedge clk) begin
        chk("iaddr", instructionAddress, (stall ? m_inf : m_next) & ~32'h7);
        chk("a_valid", instructionA_valid, e_av);
        chk("b_valid", instructionB_valid, e_bv);
        chk("pred_a", predTakenA, e_pa);
        chk("pred_b", predTakenB, e_pb);
        if (!reset) begin
            chk("rst_instr_a", instructionA, 32'h0);
            chk("rst_instr_b", instructionB, 32'h0);
            chk("rst_addr_a", addressA, 32'h0);
            chk("rst_addr_b", addressB, 32'h0);
        end else if (e_av) begin
            chk("instr_a", instructionA, e_a);
            chk("addr_a", addressA, e_aa);
            chk("addr_b", addressB, e_ab);
            if (e_bchk) chk("instr_b", instructionB, e_b);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pkt(input string nm, input logic [31:0] a, input logic [31:0] pa,
                       input logic bv, input logic [31:0] b);
        chk({nm, "_av"}, instructionA_valid, 1'b1);
        chk({nm, "_a"}, instructionA, a);
        chk({nm, "_pa"}, addressA, pa);
        chk({nm, "_bv"}, instructionB_valid, bv);
        chk({nm, "_b"}, instructionB, b);
        chk({nm, "_pb"}, addressB, pa + 32'd4);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("boot_iaddr", instructionAddress, 32'h0);
        step(2);
        pkt("first", 32'h0000_0000, 32'h0, 1'b1, 32'h1111_1111);
        chk("step_iaddr", instructionAddress, 32'h10);
        step(1);
        pkt("second", 32'h2222_2222, 32'h8, 1'b1, 32'h3333_3333);

        branchTarget = 32'h14; branchTaken = 1'b1;
        step(1);
        branchTaken = 1'b0;
        chk("redir_av", instructionA_valid, 1'b0);
        chk("redir_bv", instructionB_valid, 1'b0);
        step(1);
        chk("bubble_av", instructionA_valid, 1'b0);
        step(1);
        pkt("tgt14", 32'h5555_5555, 32'h14, 1'b0, 32'h0);
        step(1);
        pkt("tgt18", 32'h6666_6666, 32'h18, 1'b1, 32'h7777_7777);

        stall = 1'b1;
        step(1);
        chk("stall1_iaddr", instructionAddress, 32'h20);
        chk("stall1_hold", instructionA, 32'h6666_6666);
        stall = 1'b0;
        step(1);
        pkt("after1", 32'h8888_8888, 32'h20, 1'b1, 32'h9999_9999);
        stall = 1'b1;
        step(4);
        chk("stall4_iaddr", instructionAddress, 32'h28);
        chk("stall4_hold", instructionA, 32'h8888_8888);
        stall = 1'b0;
        step(1);
        pkt("after4", 32'hAAAA_AAAA, 32'h28, 1'b1, 32'hBBBB_BBBB);

        stall = 1'b1; branchTarget = 32'h14; branchTaken = 1'b1;
        step(1);
        branchTaken = 1'b0;
        chk("stredir_av", instructionA_valid, 1'b0);
        step(1);
        stall = 1'b0;
        step(1);
        chk("stredir_bubble", instructionA_valid, 1'b0);
        step(1);
        pkt("stredir_tgt", 32'h5555_5555, 32'h14, 1'b0, 32'h0);

        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_av", instructionA_valid, 1'b0);
        chk("arst_bv", instructionB_valid, 1'b0);
        chk("arst_iaddr", instructionAddress, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(8);
        pkt("pkt30", 32'hCCCC_CCCC, 32'h30, 1'b1, 32'hFE00_00E3);
`ifdef STATIC_BTFN_EN
        chk("pkt30_predb", predTakenB, 1'b1);
        step(1);
        chk("loop_bubble", instructionA_valid, 1'b0);
        step(1);
        pkt("loop14", 32'h5555_5555, 32'h14, 1'b0, 32'h0);
`else
        chk("pkt30_predb", predTakenB, 1'b0);
        step(1);
        pkt("pkt38", 32'hEEEE_EEEE, 32'h38, 1'b1, 32'hFFFF_FFFF);
`endif

        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(0, 99) < 30);
            if (!branchTaken && $urandom_range(0, 99) < 6) begin
                branchTaken = 1'b1;
                branchTarget = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            end else begin
                branchTaken = 1'b0;
            end
            step(1);
        end
        stall = 1'b0; branchTaken = 1'b0;
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
Front-end fetch stage of the dual-issue RISC-V pipeline. Each cycle it issues one 8-byte-aligned address to a synchronous 64-bit instruction memory. It splits the returned doubleword into two program-ordered instruction slots (A, B), each with its own valid and PC. It also handles pipeline stall, redirects from the execute stage, and (optionally) static backward-branch prediction.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
fetchedInstruction  in  64  memory read data for the address presented one cycle earlier; [31:0]=word at addr, [63:32]=word at addr+4.
stall  in  1  downstream not accepting; hold outputs.
branchTarget  in  32  redirect address (bits [1:0] ignored).
branchTaken  in  1  redirect request, single-cycle pulse.
instructionAddress  out  32  memory read address, bits [2:0] always 0.
instructionA  out  32  oldest instruction.
instructionB  out  32  next instruction (A's PC + 4).
instructionA_valid  out  1  slot A holds a valid instruction.
instructionB_valid  out  1  slot B holds a valid instruction.
addressA  out  32  PC of instructionA.
addressB  out  32  PC of instructionB.
predTakenA  out  1  slot A predicted taken (Optional Feature).
predTakenB  out  1  slot B predicted taken (Optional Feature).

Behaviour:
- State:
  - pc: next fetch PC, word-aligned.
  - reqPC/reqValid: the request whose data is on fetchedInstruction this cycle.
  - All outputs are registered.
- Reset (reset=0, async):
  - pc=RESET_PC, reqValid=0, reqPC=0.
  - All valids 0; instruction/address outputs 0; pred flags 0.
- instructionAddress = {P[31:3],3'b000}, where P = reqPC if stall=1, else pc. This is combinational. While stalled, the in-flight request is re-read, so no data is lost.
- Memory latency is 1 cycle. Outputs update 2 edges after the address is presented.
- Normal cycle (stall=0, branchTaken=0):
  - reqPC<=pc, reqValid<=1, pc<={pc[31:3],3'b0}+8.
  - Output registers load from fetchedInstruction using reqPC/reqValid:
    - reqPC[2]=0: A=low word @reqPC, B=high word @reqPC+4, both valid.
    - reqPC[2]=1: A=high word @reqPC, A valid, B invalid (B=0, addressB=reqPC+4).
    - reqValid=0: both valids 0.
- Stall cycle (stall=1, branchTaken=0): pc, reqPC, reqValid and all outputs hold.
- Redirect (branchTaken=1): has priority over stall and prediction.
  - pc<={branchTarget[31:2],2'b00}, reqValid<=0.
  - Both output valids cleared, including data held during a stall.
  - First target instruction appears 3 edges after the redirect edge if no stall intervenes.
  - If stall=1 after the redirect, no request is issued until stall drops; then one bubble cycle precedes the target.
- Misaligned target (target[2]=1): first packet is single-instruction (A only). Fetch continues at the next 8-byte boundary.
- Consumer contract: slot data is taken on a rising edge where stall=0 and valid=1. B is never valid without A.
- Addresses wrap modulo 2^32.

Optional Feature:
STATIC_BTFN_EN.
- Defined: when loading output registers, predecode each valid slot in order.
  - A B-type instruction (opcode 7'b1100011) with imm[12]=1, or any JAL (7'b1101111), is predicted taken. Its target is slot PC + sign-extended immediate.
  - On the first predicted slot: set predTakenX=1, pc<=target, reqValid<=0.
  - If the predicted slot is A, B is invalidated.
  - Applies only on non-stall cycles without branchTaken.
- Undefined: predTakenA/B tied 0; no redirect other than branchTaken.

Test Plan:
- Memory model: mem[n] at address 8n. mem[0]=11111111_00000000, mem[1]=33333333_22222222, …, mem[6]=FE0000E3_CCCCCCCC.
- Reset release, no stall -> first packet A=00000000@0, B=11111111@4, both valid; then 22222222@8 / 33333333@C; instructionAddress steps 0,8,10,…
- branchTaken=1, target=0x14, one cycle -> older valids drop; next valid packet is A=55555555@14 with B invalid; then A=66666666@18, B=77777777@1C.
- stall=1 for 1 and for 4 cycles mid-stream -> outputs frozen, instructionAddress equals held request; after release, sequence resumes with no skipped or duplicated instruction.
- branchTaken=1 while stall=1 (target 0x14), release stall 1 cycle later -> held packet discarded; stream restarts at 55555555@14.
- Reset asserted asynchronously mid-stream -> all valids 0 immediately; restart at RESET_PC.
- STATIC_BTFN_EN defined, run to 0x30 -> packet A=CCCCCCCC@30, B=FE0000E3@34 with predTakenB=1; next valid instruction 55555555@14 (loop). Undefined -> fetch continues to 0x38 (EEEEEEEE).
